// File: rtl/sc_pointtype_pkg.sv
// Shared types for the point-type pattern controller and the shift register it drives.
package sc_pointtype_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_TRANS = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10
  } shift_t;

  localparam int STEP_W = 8;

  function automatic shift_t shift_code(input logic dir);
    return dir ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running tick divider: counts enabled cycles 0..TICK_DIV-1 and flags the last one.
module sc_tick_prescaler #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sc_pointtype_ctrl.sv
// Sequencer for the point-type pattern register: clear, load, timed shifts and
// level-up transition loads, all as one-cycle Moore command pulses.
//   state | meaning
//   IDLE  | waiting for a start_InLow falling edge
//   CLEAR | clear_OutLow pulse
//   LOAD  | load0/load1 pulse per latched pattern select
//   RUN   | prescaler running toward the next shift tick
//   SHIFT | one shift command, step counter advances
//   TRANS | transition load of the captured level-up pattern
//   DONE  | done_Out pulse before returning to IDLE
module sc_pointtype_ctrl
  import sc_pointtype_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int TICK_DIV    = 2500000,
  parameter int SHIFT_STEPS = 8
) (
  input  logic                 SC_RegPOINTTYPE_CLOCK_50,
  input  logic                 SC_RegPOINTTYPE_RESET_InHigh,
  input  logic                 start_InLow,
  input  logic                 patternsel_In,
  input  logic                 direction_In,
  input  logic                 pause_InLow,
  input  logic                 levelup_In,
  input  logic [DATAWIDTH-1:0] transpattern_InBUS,
  output logic                 clear_OutLow,
  output logic                 load0_OutLow,
  output logic                 load1_OutLow,
  output logic [1:0]           shiftselection_Out,
  output logic                 transition_Out,
  output logic [DATAWIDTH-1:0] transitionDATA_OutBUS,
  output logic                 busy_Out,
  output logic                 done_Out
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SHIFT_STEPS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                start_hist;
  logic                lvl_hist;
  logic                sel_lat;
  logic                dir_lat;
  logic [STEP_W-1:0]   step_cnt;
  logic [DATAWIDTH-1:0] trans_data;
  logic                start_fall;
  logic                lvl_rise;
  logic                presc_en;
  logic                presc_restart;
  logic                tick;

  assign start_fall    = start_hist & ~start_InLow;
  assign lvl_rise      = levelup_In & ~lvl_hist;
  assign presc_en      = (state == ST_RUN) && pause_InLow;
  assign presc_restart = (state != ST_RUN);

  sc_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_sys (SC_RegPOINTTYPE_CLOCK_50),
    .rst     (SC_RegPOINTTYPE_RESET_InHigh),
    .enable  (presc_en),
    .restart (presc_restart),
    .tick    (tick)
  );

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      start_hist <= 1'b1;
      lvl_hist   <= 1'b0;
    end else begin
      start_hist <= start_InLow;
      lvl_hist   <= levelup_In;
    end
  end

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run options are frozen at the accepted start edge so mid-run input changes are harmless.
  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      sel_lat <= 1'b0;
      dir_lat <= 1'b0;
    end else if ((state == ST_IDLE) && start_fall) begin
      sel_lat <= patternsel_In;
      dir_lat <= direction_In;
    end
  end

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      trans_data <= '0;
    end else if ((state == ST_RUN) && lvl_rise) begin
      trans_data <= transpattern_InBUS;
    end
  end

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      step_cnt <= '0;
    end else begin
      unique case (state)
        ST_SHIFT: step_cnt <= step_cnt + STEP_W'(1);
        ST_TRANS,
        ST_IDLE:  step_cnt <= '0;
        default:  step_cnt <= step_cnt;
      endcase
    end
  end

  // A level-up edge outranks a coincident prescaler tick; that tick is simply lost.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_fall) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_RUN;
      ST_RUN: begin
        if (lvl_rise) begin
          state_nxt = ST_TRANS;
        end else if (tick) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: state_nxt = (step_cnt == LAST_STEP) ? ST_DONE : ST_RUN;
      ST_TRANS: state_nxt = ST_RUN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_OutLow          = 1'b1;
    load0_OutLow          = 1'b1;
    load1_OutLow          = 1'b1;
    shiftselection_Out    = SHIFT_NONE;
    transition_Out        = 1'b0;
    transitionDATA_OutBUS = '0;
    busy_Out              = (state != ST_IDLE);
    done_Out              = 1'b0;
    unique case (state)
      ST_CLEAR: clear_OutLow = 1'b0;
      ST_LOAD: begin
        load0_OutLow = sel_lat;
        load1_OutLow = ~sel_lat;
      end
      ST_SHIFT: shiftselection_Out = shift_code(dir_lat);
      ST_TRANS: begin
        transition_Out        = 1'b1;
        transitionDATA_OutBUS = trans_data;
      end
      ST_DONE:  done_Out = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_sc_pointtype_ctrl.sv
// Bench for sc_pointtype_ctrl: directed scenarios plus random stimulus against a script-based reference model.
module tb_sc_pointtype_ctrl;

  localparam int TDIV   = 4;
  localparam int NSTEPS = 3;

  localparam int K_IDLE  = 0;
  localparam int K_CLEAR = 1;
  localparam int K_LOAD  = 2;
  localparam int K_RUN   = 3;
  localparam int K_SHIFT = 4;
  localparam int K_TRANS = 5;
  localparam int K_DONE  = 6;

  logic       clk;
  logic       rst;
  logic       start_InLow;
  logic       patternsel_In;
  logic       direction_In;
  logic       pause_InLow;
  logic       levelup_In;
  logic [7:0] transpattern_InBUS;
  logic       clear_OutLow;
  logic       load0_OutLow;
  logic       load1_OutLow;
  logic [1:0] shiftselection_Out;
  logic       transition_Out;
  logic [7:0] transitionDATA_OutBUS;
  logic       busy_Out;
  logic       done_Out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: what the outputs show this cycle, plus a script of upcoming one-cycle commands
  int         shown;
  int         script[$];
  int         credit;
  int         steps;
  bit         m_busy;
  bit         m_sel;
  bit         m_dir;
  logic [7:0] m_data;
  bit         prev_start;
  bit         prev_lvl;

  sc_pointtype_ctrl #(
    .DATAWIDTH   (8),
    .TICK_DIV    (TDIV),
    .SHIFT_STEPS (NSTEPS)
  ) dut (
    .SC_RegPOINTTYPE_CLOCK_50     (clk),
    .SC_RegPOINTTYPE_RESET_InHigh (rst),
    .start_InLow                  (start_InLow),
    .patternsel_In                (patternsel_In),
    .direction_In                 (direction_In),
    .pause_InLow                  (pause_InLow),
    .levelup_In                   (levelup_In),
    .transpattern_InBUS           (transpattern_InBUS),
    .clear_OutLow                 (clear_OutLow),
    .load0_OutLow                 (load0_OutLow),
    .load1_OutLow                 (load1_OutLow),
    .shiftselection_Out           (shiftselection_Out),
    .transition_Out               (transition_Out),
    .transitionDATA_OutBUS        (transitionDATA_OutBUS),
    .busy_Out                     (busy_Out),
    .done_Out                     (done_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] act_vec();
    return {clear_OutLow, load0_OutLow, load1_OutLow, shiftselection_Out,
            transition_Out, transitionDATA_OutBUS, busy_Out, done_Out};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [1:0] sh;
    logic       tr;
    sh = (shown == K_SHIFT) ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
    tr = (shown == K_TRANS);
    return {!(shown == K_CLEAR), !(shown == K_LOAD && !m_sel), !(shown == K_LOAD && m_sel),
            sh, tr, (tr ? m_data : 8'h00), (shown != K_IDLE), (shown == K_DONE)};
  endfunction

  task automatic model_reset();
    shown = K_IDLE;
    script.delete();
    credit = 0;
    steps = 0;
    m_busy = 0;
    m_data = 8'h00;
    prev_start = 1;
    prev_lvl = 0;
  endtask

  task automatic model_step();
    bit sf;
    bit lr;
    if (rst) begin
      model_reset();
      return;
    end
    sf = prev_start && !start_InLow;
    lr = levelup_In && !prev_lvl;
    prev_start = start_InLow;
    prev_lvl = levelup_In;
    if (shown == K_IDLE && sf) begin
      m_sel = patternsel_In;
      m_dir = direction_In;
      script.push_back(K_CLEAR);
      script.push_back(K_LOAD);
      m_busy = 1;
      credit = 0;
      steps = 0;
    end else if (shown == K_RUN) begin
      if (lr) begin
        m_data = transpattern_InBUS;
        script.push_back(K_TRANS);
        credit = 0;
        steps = 0;
      end else if (pause_InLow) begin
        credit++;
        if (credit == TDIV) begin
          credit = 0;
          steps++;
          script.push_back(K_SHIFT);
          if (steps == NSTEPS) script.push_back(K_DONE);
        end
      end
    end
    if (script.size() > 0) begin
      shown = script.pop_front();
      if (shown == K_DONE) m_busy = 0;
    end else begin
      shown = m_busy ? K_RUN : K_IDLE;
    end
  endtask

  task automatic compare_outputs();
    logic [15:0] a;
    logic [15:0] e;
    a = act_vec();
    e = exp_vec();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, a, e);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp_val);
    n_checks++;
    if (act != exp_val) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_val);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  task automatic start_run(input bit sel, input bit dir);
    patternsel_In = sel;
    direction_In = dir;
    start_InLow = 1'b0;
    tick_cycle();
    start_InLow = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start_InLow = 1'b1;
    patternsel_In = 1'b0;
    direction_In = 1'b0;
    pause_InLow = 1'b1;
    levelup_In = 1'b0;
    transpattern_InBUS = 8'h00;
    model_reset();
    #2;
    check_lit("reset_state", int'(act_vec()), 32'hE000);
    repeat (3) tick_cycle();
    rst = 1'b0;
    repeat (2) tick_cycle();

    // basic run: load0, left shifts at offsets 6/11/16, done at 17
    start_run(1'b0, 1'b0);
    check_lit("clear_pulse", int'(clear_OutLow), 0);
    check_lit("model_clear", shown, K_CLEAR);
    for (int j = 1; j <= 19; j++) begin
      tick_cycle();
      if (j == 1) check_lit("load0_pulse", int'(load0_OutLow), 0);
      if (j == 6 || j == 11 || j == 16) check_lit("shift_left", int'(shiftselection_Out), 1);
      if (j == 6) check_lit("model_shift", shown, K_SHIFT);
      if (j == 7) check_lit("shift_one_cycle", int'(shiftselection_Out), 0);
      if (j == 17) check_lit("done_pulse", int'(done_Out), 1);
      if (j == 18) check_lit("busy_fall", int'(busy_Out), 0);
    end

    // load1 and right shifts
    start_run(1'b1, 1'b1);
    for (int j = 1; j <= 19; j++) begin
      tick_cycle();
      if (j == 1) check_lit("load1_pulse", int'(load1_OutLow), 0);
      if (j == 1) check_lit("load0_quiet", int'(load0_OutLow), 1);
      if (j == 6 || j == 11 || j == 16) check_lit("shift_right", int'(shiftselection_Out), 2);
      if (j == 17) check_lit("done_pulse2", int'(done_Out), 1);
    end

    // level-up coinciding with terminal count: trans wins, steps restart
    start_run(1'b0, 1'b0);
    for (int j = 1; j <= 24; j++) begin
      tick_cycle();
      if (j == 6) begin
        check_lit("trans_pulse", int'(transition_Out), 1);
        check_lit("trans_data", int'(transitionDATA_OutBUS), 8'hA5);
        check_lit("no_shift_on_trans", int'(shiftselection_Out), 0);
      end
      if (j == 7) check_lit("trans_data_cleared", int'(transitionDATA_OutBUS), 0);
      if (j == 11 || j == 16 || j == 21) check_lit("shift_after_trans", int'(shiftselection_Out), 1);
      if (j == 22) check_lit("done_after_trans", int'(done_Out), 1);
      if (j == 5) begin
        levelup_In = 1'b1;
        transpattern_InBUS = 8'hA5;
      end
      if (j == 7) levelup_In = 1'b0;
    end

    // pause for 10 cycles delays the first shift from offset 6 to 16
    start_run(1'b0, 1'b0);
    for (int j = 1; j <= 29; j++) begin
      tick_cycle();
      if (j == 6) check_lit("paused_no_shift", int'(shiftselection_Out), 0);
      if (j == 16) check_lit("paused_shift", int'(shiftselection_Out), 1);
      if (j == 27) check_lit("paused_done", int'(done_Out), 1);
      if (j == 2) pause_InLow = 1'b0;
      if (j == 12) pause_InLow = 1'b1;
    end

    // second start mid-run ignored, then reset during SHIFT
    start_run(1'b0, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      tick_cycle();
      if (j == 3) start_InLow = 1'b0;
      if (j == 4) start_InLow = 1'b1;
    end
    check_lit("shift_before_reset", int'(shiftselection_Out), 2);
    rst = 1'b1;
    #1;
    check_lit("reset_mid_shift", int'(act_vec()), 32'hE000);
    tick_cycle();
    rst = 1'b0;
    repeat (20) tick_cycle();
    check_lit("idle_after_reset", int'(busy_Out), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start_InLow = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 9) == 0) levelup_In = ~levelup_In;
      pause_InLow = ($urandom_range(0, 5) != 0);
      patternsel_In = 1'($urandom_range(0, 1));
      direction_In = 1'($urandom_range(0, 1));
      transpattern_InBUS = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 399) == 0);
      tick_cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
